// File: rtl/freq_meas.sv
// -----------------------------------------------------------------------------
// freq_meas : receive-side checker for a divided clock / pulse train.
//
// The incoming signal is synchronised into the clk domain, its rising edges
// are detected, and two free-running counters measure the distance between
// consecutive rising edges (period) and the number of cycles the signal was
// high inside that interval (high_len). Each completed measurement is
// published with a one-cycle valid strobe and compared against the expected
// even division ratio. If no rising edge arrives for TIMEOUT_CYC cycles the
// block declares loss of signal until the next rising edge.
//
// Parameters
//   EXP_DIV     expected period in clk cycles (even, >= 2)
//   CNT_W       counter / output width (2^CNT_W-1 >= TIMEOUT_CYC)
//   TIMEOUT_CYC cycles without a rising edge before no_signal (> EXP_DIV)
//   SYNC_STAGES number of input synchroniser flops (>= 1)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   sig_in    in   divided signal under measurement (asynchronous)
//   period    out  last measured period in clk cycles
//   high_len  out  high cycles within that period
//   valid     out  one-cycle strobe, period/high_len just updated
//   match     out  last measurement equalled EXP_DIV / EXP_DIV/2
//   no_signal out  timeout reached, held until the next rising edge
// -----------------------------------------------------------------------------
module freq_meas #(
    parameter int EXP_DIV     = 14,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic             valid,
    output logic             match,
    output logic             no_signal
);

    // Width-matched versions of the integer parameters.
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] EXP_PER_V = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] EXP_HI_V  = CNT_W'(EXP_DIV / 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sig_d_r;
    logic                   sig_s;
    logic                   rise_s;

    // Free-running measurement counters
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       hcnt_r;
    logic                   timeout_s;

    // FSM and published results
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       period_r;
    logic [CNT_W-1:0]       period_nxt_s;
    logic [CNT_W-1:0]       high_len_r;
    logic [CNT_W-1:0]       high_len_nxt_s;
    logic                   valid_r;
    logic                   valid_nxt_s;
    logic                   match_r;
    logic                   match_nxt_s;
    logic                   no_signal_r;
    logic                   no_signal_nxt_s;

    assign sig_s     = sync_r[SYNC_STAGES-1];
    assign rise_s    = sig_s & ~sig_d_r;
    // cnt_r equals TIMEOUT_CYC exactly TIMEOUT_CYC edges after the last rise
    // was acted on, because the rise itself loads 1.
    assign timeout_s = (cnt_r == TIMEOUT_V);

    // Input synchroniser chain plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            sig_d_r <= 1'b0;
        end else begin
            sync_r[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            sig_d_r <= sig_s;
        end
    end

    // Period and high-time counters; both restart at 1 on every rising edge
    // (the rise cycle itself is a high cycle) and saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            hcnt_r <= {CNT_W{1'b0}};
        end else begin
            if (rise_s) begin
                cnt_r  <= CNT_ONE;
                hcnt_r <= CNT_ONE;
            end else begin
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
                if (sig_s && (hcnt_r != CNT_MAX)) begin
                    hcnt_r <= hcnt_r + CNT_ONE;
                end else begin
                    hcnt_r <= hcnt_r;
                end
            end
        end
    end

    // Next-state and next-output logic. A rise always takes priority over a
    // coincident timeout so a late-but-present edge is still measured.
    always_comb begin
        state_nxt_s     = state_r;
        period_nxt_s    = period_r;
        high_len_nxt_s  = high_len_r;
        valid_nxt_s     = 1'b0;
        match_nxt_s     = match_r;
        no_signal_nxt_s = no_signal_r;

        case (state_r)
            ST_IDLE: begin
                // First edge only establishes the reference; nothing to publish.
                if (rise_s) begin
                    state_nxt_s = ST_MEASURE;
                end else if (timeout_s) begin
                    state_nxt_s     = ST_LOST;
                    no_signal_nxt_s = 1'b1;
                    match_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_MEASURE: begin
                if (rise_s) begin
                    period_nxt_s   = cnt_r;
                    high_len_nxt_s = hcnt_r;
                    match_nxt_s    = (cnt_r == EXP_PER_V) && (hcnt_r == EXP_HI_V);
                    valid_nxt_s    = 1'b1;
                    state_nxt_s    = ST_MEASURE;
                end else if (timeout_s) begin
                    // Keep the last good period/high_len for post-mortem reads.
                    state_nxt_s     = ST_LOST;
                    no_signal_nxt_s = 1'b1;
                    match_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end

            ST_LOST: begin
                // The returning edge becomes the new reference; the interval
                // before it is meaningless, so no valid here.
                if (rise_s) begin
                    state_nxt_s     = ST_MEASURE;
                    no_signal_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_LOST;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                period_nxt_s    = {CNT_W{1'b0}};
                high_len_nxt_s  = {CNT_W{1'b0}};
                match_nxt_s     = 1'b0;
                no_signal_nxt_s = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            period_r    <= {CNT_W{1'b0}};
            high_len_r  <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            match_r     <= 1'b0;
            no_signal_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            period_r    <= period_nxt_s;
            high_len_r  <= high_len_nxt_s;
            valid_r     <= valid_nxt_s;
            match_r     <= match_nxt_s;
            no_signal_r <= no_signal_nxt_s;
        end
    end

    assign period    = period_r;
    assign high_len  = high_len_r;
    assign valid     = valid_r;
    assign match     = match_r;
    assign no_signal = no_signal_r;

endmodule
